// File: rtl/lp_pkg.sv
// Shared low-power arithmetic definitions: gating FSM states and
// pipeline geometry helpers used by the clock-gated datapath blocks.
package lp_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IDLE_WAIT = 2'd1,
    GATED     = 2'd2
  } lp_state_e;

  function automatic int unsigned seg_width(input int unsigned width,
                                            input int unsigned stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int unsigned width,
                                input int unsigned stages,
                                input int unsigned idle_cycles);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0) &&
           (idle_cycles >= 1);
  endfunction

endpackage

// File: rtl/cg_icg.sv
// Latch-based integrated clock gate: enable is captured while clk is low so
// gclk never glitches when the enable changes during the high phase.
module cg_icg (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_latch;

  always_latch begin
    if (!clk) en_latch <= en;
  end

  assign gclk = clk & en_latch;

endmodule

// File: rtl/adder_pipe_cg.sv
// Pipelined WIDTH-bit carry-segmented adder with valid handshake, idle-detect
// clock gating of the datapath and a saturating gated-cycle counter.
module adder_pipe_cg
  import lp_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  input  logic             CG,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             out_valid,
  output logic             gated,
  output logic [CNT_W-1:0] gated_cycles
);

  localparam int unsigned SEG  = seg_width(WIDTH, STAGES);
  localparam int unsigned IC_W = $clog2(IDLE_CYCLES + 1);

  if (!cfg_ok(WIDTH, STAGES, IDLE_CYCLES)) begin : g_bad_cfg
    $error("adder_pipe_cg: WIDTH must divide by STAGES and IDLE_CYCLES >= 1");
  end

  // ---------------- control domain (clk) ----------------
  logic [STAGES:0] v_d, v_q;
  logic            out_valid_d, out_valid_q;
  lp_state_e       state_d, state_q;
  logic [IC_W-1:0] idle_cnt_d, idle_cnt_q;
  logic [CNT_W-1:0] gcnt_d, gcnt_q;
  logic            pipe_busy;
  logic            dp_en;
  logic            gclk;

  // v_q[0] marks the operand register, v_q[k+1] the register after segment k
  assign pipe_busy = |v_q;

  always_comb begin
    v_d         = {v_q[STAGES-1:0], in_valid};
    out_valid_d = v_q[STAGES];
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    gcnt_d      = gcnt_q;

    unique case (state_q)
      RUN: begin
        if (in_valid || pipe_busy) begin
          idle_cnt_d = '0;
        end else begin
          state_d    = IDLE_WAIT;
          idle_cnt_d = IC_W'(1);
        end
      end
      IDLE_WAIT: begin
        if (in_valid) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else if (!CG) begin
          idle_cnt_d = IC_W'(IDLE_CYCLES);
        end else if (idle_cnt_q == IC_W'(IDLE_CYCLES)) begin
          state_d = GATED;
        end else begin
          idle_cnt_d = idle_cnt_q + IC_W'(1);
        end
      end
      GATED: begin
        if (in_valid || !CG) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = RUN;
        idle_cnt_d = '0;
      end
    endcase

    if ((state_q == GATED) && (gcnt_q != '1)) begin
      gcnt_d = gcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
      state_q     <= RUN;
      idle_cnt_q  <= '0;
      gcnt_q      <= '0;
    end else begin
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      gcnt_q      <= gcnt_d;
    end
  end

  // in_valid is combinational here so a gated datapath wakes without a bubble
  assign dp_en = ~CG | in_valid | pipe_busy | (state_q != GATED);

  cg_icg u_icg (
    .clk  (clk),
    .en   (dp_en),
    .gclk (gclk)
  );

  // ---------------- datapath domain (gclk) ----------------
  logic [WIDTH-1:0] a_d   [STAGES+1];
  logic [WIDTH-1:0] a_q   [STAGES+1];
  logic [WIDTH-1:0] b_d   [STAGES+1];
  logic [WIDTH-1:0] b_q   [STAGES+1];
  logic [WIDTH-1:0] sum_d [STAGES+1];
  logic [WIDTH-1:0] sum_q [STAGES+1];
  logic             c_d   [STAGES+1];
  logic             c_q   [STAGES+1];
  logic [SEG:0]     seg_sum;
  logic [WIDTH-1:0] sum_out_d, sum_out_q;
  logic             carry_out_d, carry_out_q;

  // Every stage carries full-width operand/sum words; segment j-1 is resolved
  // in stage j while lower sum bits and upper operand bits ride along.
  always_comb begin
    a_d[0]   = a_in;
    b_d[0]   = b_in;
    sum_d[0] = '0;
    c_d[0]   = carry_in;
    seg_sum  = '0;
    for (int unsigned j = 1; j <= STAGES; j++) begin
      seg_sum  = {1'b0, a_q[j-1][(j-1)*SEG +: SEG]} +
                 {1'b0, b_q[j-1][(j-1)*SEG +: SEG]} +
                 (SEG+1)'(c_q[j-1]);
      a_d[j]   = a_q[j-1];
      b_d[j]   = b_q[j-1];
      sum_d[j] = sum_q[j-1];
      sum_d[j][(j-1)*SEG +: SEG] = seg_sum[SEG-1:0];
      c_d[j]   = seg_sum[SEG];
    end
    sum_out_d   = sum_q[STAGES];
    carry_out_d = c_q[STAGES];
  end

  always_ff @(posedge gclk or negedge reset_b) begin
    if (!reset_b) begin
      for (int unsigned j = 0; j <= STAGES; j++) begin
        a_q[j]   <= '0;
        b_q[j]   <= '0;
        sum_q[j] <= '0;
        c_q[j]   <= 1'b0;
      end
      sum_out_q   <= '0;
      carry_out_q <= 1'b0;
    end else begin
      for (int unsigned j = 0; j <= STAGES; j++) begin
        if (v_d[j]) begin
          a_q[j]   <= a_d[j];
          b_q[j]   <= b_d[j];
          sum_q[j] <= sum_d[j];
          c_q[j]   <= c_d[j];
        end
      end
      if (v_q[STAGES]) begin
        sum_out_q   <= sum_out_d;
        carry_out_q <= carry_out_d;
      end
    end
  end

  assign sum_out      = sum_out_q;
  assign carry_out    = carry_out_q;
  assign out_valid    = out_valid_q;
  assign gated        = (state_q == GATED);
  assign gated_cycles = gcnt_q;

endmodule

// File: tb/tb_adder_pipe_cg.sv
// Directed self-checking bench for adder_pipe_cg (WIDTH=16, STAGES=2,
// IDLE_CYCLES=4): latency, throughput, idle gating, wake-up and mid-flight reset.
module tb_adder_pipe_cg;

  localparam int unsigned WIDTH       = 16;
  localparam int unsigned STAGES      = 2;
  localparam int unsigned IDLE_CYCLES = 4;
  localparam int unsigned CNT_W       = 16;

  logic             clk = 1'b0;
  logic             reset_b;
  logic             in_valid;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic             CG;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             out_valid;
  logic             gated;
  logic [CNT_W-1:0] gated_cycles;

  int errors = 0;
  int checks = 0;
  logic saw;

  always #5 clk = ~clk;

  adder_pipe_cg #(
    .WIDTH       (WIDTH),
    .STAGES      (STAGES),
    .IDLE_CYCLES (IDLE_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .in_valid     (in_valid),
    .a_in         (a_in),
    .b_in         (b_in),
    .carry_in     (carry_in),
    .CG           (CG),
    .sum_out      (sum_out),
    .carry_out    (carry_out),
    .out_valid    (out_valid),
    .gated        (gated),
    .gated_cycles (gated_cycles)
  );

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic c);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    carry_in = c;
  endtask

  initial begin
    reset_b = 1'b0;
    CG      = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);

    #12;
    chk("rst_sum",   32'(sum_out), 32'h0);
    chk("rst_carry", 32'(carry_out), 32'h0);
    chk("rst_ov",    32'(out_valid), 32'h0);
    chk("rst_gated", 32'(gated), 32'h0);
    chk("rst_gcnt",  32'(gated_cycles), 32'h0);
    #10;
    reset_b = 1'b1;
    tick(1);

    // single op, latency STAGES+1
    drive(1'b1, 16'hA5A5, 16'h5A5A, 1'b0);
    tick(1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(2);
    chk("lat_ov_early", 32'(out_valid), 32'h0);
    tick(1);
    chk("lat_ov",    32'(out_valid), 32'h1);
    chk("lat_sum",   32'(sum_out), 32'hFFFF);
    chk("lat_carry", 32'(carry_out), 32'h0);
    tick(1);
    chk("ov_pulse",  32'(out_valid), 32'h0);
    chk("sum_hold",  32'(sum_out), 32'hFFFF);

    // idle gating: gated rises 1+IDLE+STAGES+1 = 8 edges after in_valid edge
    tick(3);
    chk("gate_early", 32'(gated), 32'h0);
    tick(1);
    chk("gate_on",    32'(gated), 32'h1);
    chk("gcnt_start", 32'(gated_cycles), 32'h0);
    tick(3);
    chk("gcnt_3",     32'(gated_cycles), 32'h3);
    chk("gated_sum",  32'(sum_out), 32'hFFFF);
    chk("gated_ov",   32'(out_valid), 32'h0);

    // wake from gated
    drive(1'b1, 16'h0001, 16'h0001, 1'b0);
    tick(1);
    chk("wake_gated", 32'(gated), 32'h0);
    chk("wake_gcnt",  32'(gated_cycles), 32'h4);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(2);
    chk("wake_ov_early", 32'(out_valid), 32'h0);
    tick(1);
    chk("wake_ov",    32'(out_valid), 32'h1);
    chk("wake_sum",   32'(sum_out), 32'h0002);
    chk("wake_carry", 32'(carry_out), 32'h0);

    // back-to-back throughput
    drive(1'b1, 16'h1707, 16'h2345, 1'b0);
    tick(1);
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
    tick(1);
    drive(1'b1, 16'h8000, 16'h8000, 1'b1);
    tick(1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(1);
    chk("b2b0_ov",    32'(out_valid), 32'h1);
    chk("b2b0_sum",   32'(sum_out), 32'h3A4C);
    chk("b2b0_carry", 32'(carry_out), 32'h0);
    tick(1);
    chk("b2b1_ov",    32'(out_valid), 32'h1);
    chk("b2b1_sum",   32'(sum_out), 32'h0000);
    chk("b2b1_carry", 32'(carry_out), 32'h1);
    tick(1);
    chk("b2b2_ov",    32'(out_valid), 32'h1);
    chk("b2b2_sum",   32'(sum_out), 32'h0001);
    chk("b2b2_carry", 32'(carry_out), 32'h1);
    tick(1);
    chk("b2b_end_ov", 32'(out_valid), 32'h0);

    // CG=0 keeps datapath clocked indefinitely
    CG  = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (gated) saw = 1'b1;
    end
    chk("cg0_never_gated", 32'(saw), 32'h0);
    chk("cg0_gcnt",        32'(gated_cycles), 32'h4);
    CG = 1'b1;
    tick(1);
    chk("cg1_regate",      32'(gated), 32'h1);
    tick(2);
    chk("cg1_gcnt",        32'(gated_cycles), 32'h6);

    // reset with two results in flight
    drive(1'b1, 16'h0003, 16'h0004, 1'b0);
    tick(1);
    drive(1'b1, 16'h0005, 16'h0006, 1'b0);
    tick(1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    reset_b = 1'b0;
    #1;
    chk("mrst_ov",    32'(out_valid), 32'h0);
    chk("mrst_sum",   32'(sum_out), 32'h0);
    chk("mrst_carry", 32'(carry_out), 32'h0);
    chk("mrst_gated", 32'(gated), 32'h0);
    chk("mrst_gcnt",  32'(gated_cycles), 32'h0);
    #3;
    reset_b = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (out_valid) saw = 1'b1;
    end
    chk("mrst_no_stale", 32'(saw), 32'h0);
    chk("mrst_sum_hold", 32'(sum_out), 32'h0);

    // full carry propagation after reset
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    tick(1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick(3);
    chk("max_ov",    32'(out_valid), 32'h1);
    chk("max_sum",   32'(sum_out), 32'hFFFF);
    chk("max_carry", 32'(carry_out), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
